// File: rtl/svc_rv_rvfi_bus_align_pkg.sv
// Shared types and constants for the RVFI data-bus alignment block.
//   bus_entry_t : one captured dmem transaction as queued for retirement
//   dl_stage_t  : one read-latency delay stage (no rdata yet)
//   ERR_*       : bit positions inside the sticky err vector
//   word_align  : clears the byte-offset bits of a bus address
package svc_rv_rvfi_bus_pkg;

  localparam int BUS_XLEN = 32;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_PROTOCOL  = 2;

  typedef struct packed {
    logic                is_write;
    logic [BUS_XLEN-1:0] addr;
    logic [3:0]          wstrb;
    logic [BUS_XLEN-1:0] wdata;
    logic [BUS_XLEN-1:0] rdata;
  } bus_entry_t;

  typedef struct packed {
    logic                valid;
    logic                is_write;
    logic [BUS_XLEN-1:0] addr;
    logic [3:0]          wstrb;
    logic [BUS_XLEN-1:0] wdata;
  } dl_stage_t;

  function automatic logic [BUS_XLEN-1:0] word_align(input logic [BUS_XLEN-1:0] a);
    return {a[BUS_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/svc_rv_rvfi_bus_align_if.sv
// Bundle of dmem issue, RVFI retire and RVFI_BUS presentation signals.
//   master : the harness side (drives dmem/rvfi, observes rvfi_bus/status)
//   slave  : the alignment block (observes dmem/rvfi, drives rvfi_bus/status)
interface svc_rv_rvfi_bus_align_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                    dmem_ren;
  logic [XLEN-1:0]         dmem_raddr;
  logic [XLEN-1:0]         dmem_rdata;
  logic                    dmem_we;
  logic [XLEN-1:0]         dmem_waddr;
  logic [XLEN-1:0]         dmem_wdata;
  logic [3:0]              dmem_wstrb;
  logic                    rvfi_valid;
  logic [3:0]              rvfi_mem_rmask;
  logic [3:0]              rvfi_mem_wmask;
  logic                    rvfi_bus_valid;
  logic                    rvfi_bus_insn;
  logic                    rvfi_bus_data;
  logic                    rvfi_bus_fault;
  logic [XLEN-1:0]         rvfi_bus_addr;
  logic [3:0]              rvfi_bus_rmask;
  logic [3:0]              rvfi_bus_wmask;
  logic [XLEN-1:0]         rvfi_bus_rdata;
  logic [XLEN-1:0]         rvfi_bus_wdata;
  logic [$clog2(DEPTH):0]  occupancy;
  logic [2:0]              err;

  modport master (
    output dmem_ren, dmem_raddr, dmem_rdata, dmem_we, dmem_waddr, dmem_wdata,
           dmem_wstrb, rvfi_valid, rvfi_mem_rmask, rvfi_mem_wmask,
    input  rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault,
           rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata,
           rvfi_bus_wdata, occupancy, err
  );

  modport slave (
    input  dmem_ren, dmem_raddr, dmem_rdata, dmem_we, dmem_waddr, dmem_wdata,
           dmem_wstrb, rvfi_valid, rvfi_mem_rmask, rvfi_mem_wmask,
    output rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault,
           rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata,
           rvfi_bus_wdata, occupancy, err
  );
endinterface

// File: rtl/svc_rv_rvfi_bus_align_fifo.sv
// DEPTH-entry synchronous FIFO of bus_entry_t.
//   clk, rst_n   : clock, synchronous active-low reset
//   push_i/data  : write an entry at the tail (ignored when full unless popping)
//   pop_i        : advance the head (ignored when empty)
//   head_o       : entry at the head, valid when occupancy_o != 0
//   occupancy_o  : number of held entries, 0..DEPTH
module svc_rv_rvfi_bus_fifo
  import svc_rv_rvfi_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  bus_entry_t       push_data_i,
  input  logic             pop_i,
  output bus_entry_t       head_o,
  output logic [OCC_W-1:0] occupancy_o
);

  bus_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push_s, do_pop_s, full_s;

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    full_s    = (occ_q == OCC_W'(DEPTH));
    do_pop_s  = pop_i && (occ_q != '0);
    do_push_s = push_i && (!full_s || do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage; contents are only meaningful below occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;

endmodule

// File: rtl/svc_rv_rvfi_bus_align.sv
// Aligns dmem bus transactions (issued in MEM) with instruction retirement
// on RVFI (WB). A read-latency delay line attaches rdata to each read, then
// transactions queue in program order and pop when a memory instruction
// retires. With an empty queue the delay-line output is bypassed straight out.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dmem issue + rvfi retire inputs, rvfi_bus_* / occupancy / err outputs
module svc_rv_rvfi_bus_align
  import svc_rv_rvfi_bus_pkg::*;
#(
  parameter int XLEN       = BUS_XLEN,
  parameter int RD_LATENCY = 1,
  parameter int DEPTH      = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  svc_rv_rvfi_bus_align_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  dl_stage_t        issue_s, dl_out_s;
  bus_entry_t       dl_entry_s, head_s, src_s;
  logic [OCC_W-1:0] occ_s;
  logic             src_valid_s, pop_req_s, fifo_empty_s, bypass_s, push_s;
  logic             fifo_pop_s, overflow_s, underflow_s, protocol_s, bus_valid_s;
  logic [2:0]       err_q, err_d;

  // Capture the issue-cycle transaction; a simultaneous read+write keeps the write.
  always_comb begin
    issue_s       = '0;
    issue_s.valid = bus.dmem_ren | bus.dmem_we;
    if (bus.dmem_we) begin
      issue_s.is_write = 1'b1;
      issue_s.addr     = word_align(bus.dmem_waddr);
      issue_s.wstrb    = bus.dmem_wstrb;
      issue_s.wdata    = bus.dmem_wdata;
    end else begin
      issue_s.addr = word_align(bus.dmem_raddr);
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_dl_comb
      assign dl_out_s = issue_s;
    end else begin : g_dl_reg
      dl_stage_t stage_q [RD_LATENCY];

      // Shift register matching the memory read latency.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LATENCY; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= issue_s;
          for (int i = 1; i < RD_LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign dl_out_s = stage_q[RD_LATENCY-1];
    end
  endgenerate

  // Delay-line output becomes a full entry; reads pick up rdata now.
  always_comb begin
    dl_entry_s.is_write = dl_out_s.is_write;
    dl_entry_s.addr     = dl_out_s.addr;
    dl_entry_s.wstrb    = dl_out_s.wstrb;
    dl_entry_s.wdata    = dl_out_s.wdata;
    if (dl_out_s.is_write) begin
      dl_entry_s.rdata = '0;
    end else begin
      dl_entry_s.rdata = bus.dmem_rdata;
    end
  end

  // Pop source selection, bypass, push and error detection.
  always_comb begin
    pop_req_s    = bus.rvfi_valid && ((bus.rvfi_mem_rmask | bus.rvfi_mem_wmask) != 4'h0);
    fifo_empty_s = (occ_s == '0);
    if (!fifo_empty_s) begin
      src_s       = head_s;
      src_valid_s = 1'b1;
    end else begin
      src_s       = dl_entry_s;
      src_valid_s = dl_out_s.valid;
    end
    bypass_s    = pop_req_s && fifo_empty_s && dl_out_s.valid;
    push_s      = dl_out_s.valid && !bypass_s;
    fifo_pop_s  = pop_req_s && !fifo_empty_s;
    overflow_s  = push_s && (occ_s == OCC_W'(DEPTH)) && !fifo_pop_s;
    bus_valid_s = pop_req_s && src_valid_s;
    underflow_s = pop_req_s && !src_valid_s;
    protocol_s  = (bus.dmem_ren && bus.dmem_we) ||
                  (bus_valid_s && (src_s.is_write != (bus.rvfi_mem_wmask != 4'h0)));
    err_d       = err_q | {protocol_s, underflow_s, overflow_s};
  end

  svc_rv_rvfi_bus_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s && !overflow_s),
    .push_data_i (dl_entry_s),
    .pop_i       (fifo_pop_s),
    .head_o      (head_s),
    .occupancy_o (occ_s)
  );

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 3'b000;
    end else begin
      err_q <= err_d;
    end
  end

  // Presentation: everything is zero unless a transaction is popped.
  always_comb begin
    bus.rvfi_bus_valid = bus_valid_s;
    bus.rvfi_bus_insn  = 1'b0;
    bus.rvfi_bus_fault = 1'b0;
    if (bus_valid_s) begin
      bus.rvfi_bus_data  = 1'b1;
      bus.rvfi_bus_addr  = src_s.addr;
      bus.rvfi_bus_rmask = src_s.is_write ? 4'h0 : 4'hf;
      bus.rvfi_bus_wmask = src_s.is_write ? src_s.wstrb : 4'h0;
      bus.rvfi_bus_rdata = src_s.is_write ? '0 : src_s.rdata;
      bus.rvfi_bus_wdata = src_s.is_write ? src_s.wdata : '0;
    end else begin
      bus.rvfi_bus_data  = 1'b0;
      bus.rvfi_bus_addr  = '0;
      bus.rvfi_bus_rmask = 4'h0;
      bus.rvfi_bus_wmask = 4'h0;
      bus.rvfi_bus_rdata = '0;
      bus.rvfi_bus_wdata = '0;
    end
  end

  assign bus.occupancy = occ_s;
  assign bus.err       = err_q;

endmodule
